axi_cmd_arbiter: RTL and testbench

Round-robin arbiter that shares one `axi_master_simple` command port among `NUM_REQ` requesters. It captures the winning requester's command and issues a single-cycle `start` to the master. It then waits for the master's `done` and routes the completion and read data back to the owner. Only one transaction is ever outstanding. The block sits between the client logic and the master, directly on the master's command interface.

---
 rtl/axi_cmd_arbiter.sv | 166 ++++++++++++++++
 tb/tb_axi_cmd_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_arbiter.sv
// Round-robin arbiter sharing one axi_master_simple command port among NUM_REQ clients.
// Define ARB_PRIO_EN to give requester 0 absolute priority over the round-robin group.
module axi_cmd_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int LEN_WIDTH  = 8,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          busy_o,
  output logic [IDX_W-1:0]              owner_o,
  output logic                          m_start_o,
  output logic                          m_write_o,
  output logic [ADDR_WIDTH-1:0]         m_addr_o,
  output logic [DATA_WIDTH-1:0]         m_wdata_o,
  output logic [LEN_WIDTH-1:0]          m_len_o,
  input  logic [DATA_WIDTH-1:0]         m_rdata_i,
  input  logic                          m_done_i
);

  // state | meaning
  // IDLE  | no command outstanding; arbitrate and capture winner
  // ISSUE | one-cycle start to master, grant to owner
  // WAIT  | command outstanding; wait for master done
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        win_idx;
  logic [IDX_W-1:0]        hi_idx;
  logic                    hi_found;
  logic                    any_req;
  logic                    sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [LEN_WIDTH-1:0]    sel_len;
  logic [NUM_REQ-1:0]      owner_oh;
  logic [IDX_W-1:0]        ptr_after_owner;
  logic                    txn_done;

  assign any_req  = |req_i;
  assign txn_done = (state == WAIT) && m_done_i;

  // Lowest requester at or above rr_ptr wins; otherwise the lowest overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    win_idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_idx = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    if (hi_found) begin
      win_idx = hi_idx;
    end
`ifdef ARB_PRIO_EN
    if (req_i[0]) begin
      win_idx = '0;
    end
`endif
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_len   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        sel_write = req_write_i[i];
        sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_len   = req_len_i[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (IDX_W'(i) == owner_o);
    end
  end

  // Explicit compare keeps the wrap correct when NUM_REQ is not a power of two.
  assign ptr_after_owner = (owner_o == LAST_IDX) ? '0 : owner_o + 1'b1;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (m_done_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign m_start_o = (state == ISSUE);
  assign gnt_o     = (state == ISSUE) ? owner_oh : '0;
  assign busy_o    = (state == ISSUE) || (state == WAIT);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rr_ptr    <= '0;
      owner_o   <= '0;
      m_write_o <= 1'b0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      m_len_o   <= '0;
      rdata_o   <= '0;
      done_o    <= '0;
    end else begin
      done_o <= '0;
      if ((state == IDLE) && any_req) begin
        owner_o   <= win_idx;
        m_write_o <= sel_write;
        m_addr_o  <= sel_addr;
        m_wdata_o <= sel_wdata;
        m_len_o   <= sel_len;
      end
      if (txn_done) begin
        done_o <= owner_oh;
        if (!m_write_o) begin
          rdata_o <= m_rdata_i;
        end
`ifdef ARB_PRIO_EN
        if (owner_o != '0) begin
          rr_ptr <= ptr_after_owner;
        end
`else
        rr_ptr <= ptr_after_owner;
`endif
      end
    end
  end

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Self-checking bench for axi_cmd_arbiter: directed scenarios plus randomized traffic
// against a queue-free round-robin reference model; a NUM_REQ=3 instance checks wrap.
module tb_axi_cmd_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  logic [N-1:0]    req_i, req_write_i;
  logic [AW-1:0]   t_addr [N];
  logic [DW-1:0]   t_wdata[N];
  logic [LW-1:0]   t_len  [N];
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N*LW-1:0] req_len_i;
  logic [N-1:0]    gnt_o, done_o;
  logic [DW-1:0]   rdata_o;
  logic            busy_o;
  logic [1:0]      owner_o;
  logic            m_start_o, m_write_o;
  logic [AW-1:0]   m_addr_o;
  logic [DW-1:0]   m_wdata_o;
  logic [LW-1:0]   m_len_o;
  logic [DW-1:0]   m_rdata_i;
  logic            m_done_i;

  always_comb begin
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_len_i   = '0;
    for (int k = 0; k < N; k++) begin
      req_addr_i[k*AW +: AW]  = t_addr[k];
      req_wdata_i[k*DW +: DW] = t_wdata[k];
      req_len_i[k*LW +: LW]   = t_len[k];
    end
  end

  axi_cmd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) u_dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_i(req_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_len_i(req_len_i),
    .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .busy_o(busy_o), .owner_o(owner_o),
    .m_start_o(m_start_o), .m_write_o(m_write_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_len_o(m_len_o), .m_rdata_i(m_rdata_i), .m_done_i(m_done_i)
  );

  // Three-requester instance for the non-power-of-two wrap case.
  logic [2:0]    r3_req, r3_gnt, r3_done;
  logic [95:0]   r3_addr;
  logic [DW-1:0] r3_rdata;
  logic          r3_busy, r3_start, r3_write, r3_mdone;
  logic [1:0]    r3_owner;
  logic [AW-1:0] r3_maddr;
  logic [DW-1:0] r3_mwdata;
  logic [LW-1:0] r3_mlen;
  assign r3_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};

  axi_cmd_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) u_dut3 (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_i(r3_req), .req_write_i(3'b000), .req_addr_i(r3_addr),
    .req_wdata_i('0), .req_len_i('0),
    .gnt_o(r3_gnt), .done_o(r3_done), .rdata_o(r3_rdata), .busy_o(r3_busy), .owner_o(r3_owner),
    .m_start_o(r3_start), .m_write_o(r3_write), .m_addr_o(r3_maddr),
    .m_wdata_o(r3_mwdata), .m_len_o(r3_mlen), .m_rdata_i(32'h0000_0033), .m_done_i(r3_mdone)
  );

  int errors = 0;
  int checks = 0;
  int mdl_ptr;
  logic [DW-1:0] mdl_rdata;

  function automatic int mdl_pick(input logic [N-1:0] r);
`ifdef ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mdl_ptr + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [LW-1:0] l);
    req_write_i[k] = wr;
    t_addr[k]      = a;
    t_wdata[k]     = d;
    t_len[k]       = l;
  endtask

  task automatic apply_reset();
    ARESET   = 1'b1;
    req_i    = '0;
    r3_req   = '0;
    m_done_i = 1'b0;
    r3_mdone = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET    = 1'b0;
    mdl_ptr   = 0;
    mdl_rdata = '0;
  endtask

  // Called at a negedge with the arbiter in IDLE and req_i already set.
  task automatic do_txn(input string tag, input bit drop, input int lat,
                        input logic [DW-1:0] rd, output int g);
    logic [N-1:0]  exp_oh;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [LW-1:0] el;
    g = mdl_pick(req_i);
    if (g < 0) begin
      checks++; errors++;
      $display("FAIL %s setup: no request pending", tag);
      return;
    end
    exp_oh = '0;
    exp_oh[g] = 1'b1;
    ew = req_write_i[g]; ea = t_addr[g]; ed = t_wdata[g]; el = t_len[g];
    @(posedge ACLK); @(negedge ACLK);
    checks++;
    if (gnt_o !== exp_oh || m_start_o !== 1'b1 || busy_o !== 1'b1 || owner_o !== 2'(g)) begin
      errors++;
      $display("FAIL %s grant: gnt=%b start=%b busy=%b owner=%0d, want gnt=%b start=1 busy=1 owner=%0d",
               tag, gnt_o, m_start_o, busy_o, owner_o, exp_oh, g);
    end
    checks++;
    if ({m_write_o, m_addr_o, m_wdata_o, m_len_o} !== {ew, ea, ed, el}) begin
      errors++;
      $display("FAIL %s cmd: wr=%b addr=%h wdata=%h len=%0d, want wr=%b addr=%h wdata=%h len=%0d",
               tag, m_write_o, m_addr_o, m_wdata_o, m_len_o, ew, ea, ed, el);
    end
    if (drop) req_i[g] = 1'b0;
    @(negedge ACLK);
    checks++;
    if (m_start_o !== 1'b0 || busy_o !== 1'b1 || gnt_o !== '0) begin
      errors++;
      $display("FAIL %s wait: start=%b busy=%b gnt=%b, want start=0 busy=1 gnt=0",
               tag, m_start_o, busy_o, gnt_o);
    end
    repeat (lat) @(negedge ACLK);
    m_done_i  = 1'b1;
    m_rdata_i = rd;
    @(negedge ACLK);
    m_done_i  = 1'b0;
    m_rdata_i = $urandom;
    if (!ew) mdl_rdata = rd;
`ifdef ARB_PRIO_EN
    if (g != 0) mdl_ptr = (g + 1) % N;
`else
    mdl_ptr = (g + 1) % N;
`endif
    checks++;
    if (done_o !== exp_oh || busy_o !== 1'b0 || rdata_o !== mdl_rdata ||
        m_start_o !== 1'b0 || m_addr_o !== ea) begin
      errors++;
      $display("FAIL %s done: done=%b busy=%b rdata=%h start=%b addr=%h, want done=%b busy=0 rdata=%h start=0 addr=%h",
               tag, done_o, busy_o, rdata_o, m_start_o, m_addr_o, exp_oh, mdl_rdata, ea);
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({gnt_o, done_o, busy_o, m_start_o, m_write_o, owner_o} !== '0 ||
        {m_addr_o, m_wdata_o, m_len_o, rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b done=%b busy=%b start=%b wr=%b owner=%0d addr=%h rdata=%h, want all 0",
               gnt_o, done_o, busy_o, m_start_o, m_write_o, owner_o, m_addr_o, rdata_o);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    int g;
    set_req(1, 1'b0, 32'h0000_0100, 32'h0, 8'd0);
    req_i = 4'b0010;
    do_txn("single_read", 1'b1, 2, 32'hCAFE_0001, g);
    checks++;
    if (g != 1 || rdata_o !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL single_read value: owner=%0d rdata=%h, want 1 cafe0001", g, rdata_o);
    end
  endtask

  task automatic test_fairness();
    int g;
    int exp_g;
    apply_reset();
    for (int k = 0; k < N; k++) set_req(k, k[0], 32'h1000 * (k + 1), $urandom, 8'(k));
    req_i = '1;
    for (int t = 0; t < 8; t++) begin
      do_txn("fairness", 1'b0, $urandom_range(0, 3), $urandom, g);
`ifdef ARB_PRIO_EN
      exp_g = 0;
`else
      exp_g = t % N;
`endif
      checks++;
      if (g != exp_g) begin
        errors++;
        $display("FAIL fairness order: txn %0d went to %0d, want %0d", t, g, exp_g);
      end
    end
    req_i = '0;
  endtask

  task automatic test_write_keeps_rdata();
    int g;
    set_req(0, 1'b0, 32'h0000_0040, 32'h0, 8'd0);
    req_i = 4'b0001;
    do_txn("rd_before_wr", 1'b1, 1, 32'h0000_0011, g);
    set_req(2, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 8'd3);
    req_i = 4'b0100;
    do_txn("write", 1'b1, 3, 32'h0BAD_0BAD, g);
    checks++;
    if (rdata_o !== 32'h0000_0011 || m_len_o !== 8'd3 || m_write_o !== 1'b1) begin
      errors++;
      $display("FAIL write_keeps_rdata: rdata=%h len=%0d wr=%b, want 00000011 3 1",
               rdata_o, m_len_o, m_write_o);
    end
  endtask

  task automatic test_spurious_done();
    int g;
    req_i    = '0;
    m_done_i = 1'b1;
    @(negedge ACLK);
    m_done_i = 1'b0;
    checks++;
    if (done_o !== '0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_done: done=%b busy=%b, want 0 0", done_o, busy_o);
    end
    @(negedge ACLK);
    req_i = '1;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, $urandom, $urandom, 8'($urandom));
    do_txn("after_spurious", 1'b1, 0, $urandom, g);
    req_i = '0;
  endtask

  task automatic test_reset_in_wait();
    int g;
    set_req(2, 1'b0, 32'h0000_2222, 32'h0, 8'd1);
    req_i = 4'b0100;
    do_txn("pre_reset", 1'b1, 0, 32'h0000_5555, g);
    set_req(1, 1'b0, 32'h0000_1111, 32'h0, 8'd2);
    req_i = 4'b0010;
    @(posedge ACLK); @(negedge ACLK);
    req_i = '0;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({gnt_o, done_o, busy_o, m_start_o, m_write_o, owner_o} !== '0 ||
        {m_addr_o, m_wdata_o, m_len_o, rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_in_wait: gnt=%b done=%b busy=%b start=%b owner=%0d addr=%h rdata=%h, want all 0",
               gnt_o, done_o, busy_o, m_start_o, owner_o, m_addr_o, rdata_o);
    end
    ARESET    = 1'b0;
    mdl_ptr   = 0;
    mdl_rdata = '0;
    set_req(3, 1'b1, 32'h0000_3333, 32'h1234_5678, 8'd0);
    req_i = 4'b1100;
    do_txn("post_reset", 1'b1, 1, $urandom, g);
    checks++;
    if (g != 2) begin
      errors++;
      $display("FAIL post_reset order: granted %0d, want 2", g);
    end
    req_i = '0;
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] add;
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < N; k++)
        if (!req_i[k]) set_req(k, 1'($urandom), $urandom, $urandom, 8'($urandom));
      add = 4'($urandom);
      req_i = req_i | add;
      if (req_i == '0) req_i[$urandom_range(0, N - 1)] = 1'b1;
      do_txn("random", 1'b1, $urandom_range(0, 4), $urandom, g);
    end
    req_i = '0;
  endtask

  task automatic test_wrap3();
    apply_reset();
    r3_req = 3'b100;
    @(posedge ACLK); @(negedge ACLK);
    checks++;
    if (r3_gnt !== 3'b100 || r3_maddr !== 32'h0000_0300) begin
      errors++;
      $display("FAIL wrap3 first: gnt=%b addr=%h, want 100 00000300", r3_gnt, r3_maddr);
    end
    r3_req = '0;
    repeat (2) @(negedge ACLK);
    r3_mdone = 1'b1;
    @(negedge ACLK);
    r3_mdone = 1'b0;
    checks++;
    if (r3_done !== 3'b100 || r3_rdata !== 32'h0000_0033) begin
      errors++;
      $display("FAIL wrap3 done: done=%b rdata=%h, want 100 00000033", r3_done, r3_rdata);
    end
    r3_req = 3'b101;
    @(posedge ACLK); @(negedge ACLK);
    checks++;
    if (r3_gnt !== 3'b001 || r3_maddr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL wrap3 second: gnt=%b addr=%h, want 001 00000100", r3_gnt, r3_maddr);
    end
    r3_req = '0;
    apply_reset();
  endtask

  initial begin
    ARESET      = 1'b1;
    req_i       = '0;
    req_write_i = '0;
    r3_req      = '0;
    r3_mdone    = 1'b0;
    m_done_i    = 1'b0;
    m_rdata_i   = '0;
    for (int k = 0; k < N; k++) set_req(k, 1'b0, '0, '0, '0);
    test_reset();
    test_single_read();
    test_fairness();
    test_write_keeps_rdata();
    test_spurious_done();
    test_reset_in_wait();
    test_random();
    test_wrap3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
